// File: rtl/voice_read_scheduler.sv
// Polyphonic DRAM read requester: each active voice posts one request per sample chunk, drained
// round-robin onto AXI-Stream. Define VOICE_STEAL_EN to reuse the voice at the arbiter pointer when all are busy.
module voice_read_scheduler #(
    parameter int NUM_VOICES    = 8,
    parameter int NUM_INSTR     = 3,
    parameter int ADDR_W        = 24,
    parameter int PERIOD_W      = 14,
    parameter int CHUNK_SAMPLES = 8,
    parameter int CHUNK_WORDS   = 8,
    parameter int PERIOD_RST    = 2272,
    localparam int INSTR_W      = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1,
    localparam int VOICE_W      = $clog2(NUM_VOICES),
    localparam int DATA_W       = INSTR_W + PERIOD_W + ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PERIOD_W-1:0]            sample_period,
    input  logic                           setup_complete,
    input  logic [NUM_INSTR:0][ADDR_W-1:0] addr_offsets,
    input  logic                           trig_valid,
    input  logic [INSTR_W-1:0]             trig_instr,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [DATA_W-1:0]              m_axis_tdata,
    output logic [VOICE_W-1:0]             m_axis_tuser,
    output logic                           m_axis_tlast,
    output logic [NUM_VOICES-1:0]          active_voices,
    output logic                           overrun,
    output logic [7:0]                     drop_count
);
    localparam int CNT_W = PERIOD_W + $clog2(CHUNK_SAMPLES);

    typedef enum logic {V_IDLE, V_ACTIVE} voice_state_e;

    voice_state_e        state_q [NUM_VOICES];
    logic [ADDR_W:0]     addr_q  [NUM_VOICES];
    logic [ADDR_W-1:0]   stop_q  [NUM_VOICES];
    logic [INSTR_W-1:0]  instr_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] pending_q;
    logic [VOICE_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, chunk_end;
    logic [PERIOD_W-1:0] period_hold_q;
    logic                tvalid_q, tlast_q, overrun_q;
    logic [DATA_W-1:0]   tdata_q;
    logic [VOICE_W-1:0]  tuser_q;
    logic [7:0]          drop_q;

    logic chunk_tick, load, grant_vld, grant_fire, grant_last, overrun_hit;
    logic [VOICE_W-1:0] grant_idx, match_idx, free_idx, trig_sel;
    logic match_vld, free_vld, sel_vld, span_ok, trig_en, trig_load, trig_drop;
    logic [ADDR_W-1:0] span_start, span_stop;
    logic [NUM_VOICES-1:0] grant_oh, trig_oh, act_after;

    assign chunk_end  = CNT_W'(period_hold_q) * CNT_W'(CHUNK_SAMPLES) - CNT_W'(1);
    assign chunk_tick = (cnt_q == chunk_end);
    assign cnt_d      = chunk_tick ? '0 : cnt_q + CNT_W'(1);

    // Stream handshake: a beat transfers on a cycle where tvalid & tready are both high; while tvalid is
    // high and tready low the beat (tdata/tuser/tlast) is held and tvalid stays high.
    assign load = !tvalid_q || m_axis_tready;

    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_VOICES) idx = idx - NUM_VOICES;
            if (!grant_vld && pending_q[idx[VOICE_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = idx[VOICE_W-1:0];
            end
        end
        grant_fire = load && grant_vld && setup_complete;
        grant_last = (addr_q[grant_idx] + (ADDR_W+1)'(CHUNK_WORDS)) >= {1'b0, stop_q[grant_idx]};
        ptr_d = ptr_q;
        if (grant_fire)
            ptr_d = (grant_idx == VOICE_W'(NUM_VOICES-1)) ? '0 : grant_idx + VOICE_W'(1);
    end

    always_comb begin
        span_start = '0;
        span_stop  = '0;
        for (int i = 0; i < NUM_INSTR; i++) begin
            if (trig_instr == INSTR_W'(i)) begin
                span_start = addr_offsets[i];
                span_stop  = addr_offsets[i+1];
            end
        end
        span_ok   = span_start < span_stop;
        match_vld = 1'b0;
        match_idx = '0;
        free_vld  = 1'b0;
        free_idx  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!match_vld && state_q[v] == V_ACTIVE && instr_q[v] == trig_instr) begin
                match_vld = 1'b1;
                match_idx = VOICE_W'(v);
            end
            if (!free_vld && state_q[v] == V_IDLE) begin
                free_vld = 1'b1;
                free_idx = VOICE_W'(v);
            end
        end
        sel_vld  = 1'b1;
        trig_sel = '0;
        if (match_vld)     trig_sel = match_idx;
        else if (free_vld) trig_sel = free_idx;
        else begin
`ifdef VOICE_STEAL_EN
            trig_sel = ptr_d;
`else
            sel_vld  = 1'b0;
`endif
        end
        trig_en   = trig_valid && setup_complete;
        trig_load = trig_en && span_ok && sel_vld;
        trig_drop = trig_en && !(span_ok && sel_vld);
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            grant_oh[v]      = grant_fire && (grant_idx == VOICE_W'(v));
            trig_oh[v]       = trig_load && (trig_sel == VOICE_W'(v));
            active_voices[v] = (state_q[v] == V_ACTIVE);
            act_after[v]     = active_voices[v] && !(grant_oh[v] && grant_last);
        end
        // A voice reloaded by a trigger or drained this cycle is not a missed chunk.
        overrun_hit = chunk_tick && setup_complete && |(pending_q & ~grant_oh & ~trig_oh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= V_IDLE;
                addr_q[v]  <= '0;
                stop_q[v]  <= '0;
                instr_q[v] <= '0;
            end
            pending_q     <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            period_hold_q <= PERIOD_W'(PERIOD_RST);
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            tuser_q       <= '0;
            tlast_q       <= 1'b0;
            overrun_q     <= 1'b0;
            drop_q        <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (chunk_tick) period_hold_q <= sample_period;
            if (load) begin
                tvalid_q <= grant_fire;
                if (grant_fire) begin
                    tdata_q <= {instr_q[grant_idx], period_hold_q, addr_q[grant_idx][ADDR_W-1:0]};
                    tuser_q <= grant_idx;
                    tlast_q <= grant_last;
                end
            end
            ptr_q <= ptr_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (grant_oh[v]) begin
                    pending_q[v] <= 1'b0;
                    addr_q[v]    <= addr_q[v] + (ADDR_W+1)'(CHUNK_WORDS);
                    if (grant_last) state_q[v] <= V_IDLE;
                end
                if (chunk_tick && act_after[v]) pending_q[v] <= 1'b1;
                if (trig_oh[v]) begin
                    state_q[v]   <= V_ACTIVE;
                    pending_q[v] <= 1'b1;
                    addr_q[v]    <= {1'b0, span_start};
                    stop_q[v]    <= span_stop;
                    instr_q[v]   <= trig_instr;
                end
                if (!setup_complete) begin
                    state_q[v]   <= V_IDLE;
                    pending_q[v] <= 1'b0;
                end
            end
            if (overrun_hit) overrun_q <= 1'b1;
            if (trig_drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign overrun       = overrun_q;
    assign drop_count    = drop_q;
endmodule

// File: tb/tb_voice_read_scheduler.sv
// Bench for voice_read_scheduler: directed scenarios plus random traffic against a transaction-level model.
module tb_voice_read_scheduler;
    localparam int NV = 8, NI = 3, AW = 24, PW = 14, CS = 8, CWD = 8, PRST = 5;
    localparam int IW = 2, VW = 3, DW = IW + PW + AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [PW-1:0] sample_period;
    logic setup_complete;
    logic [NI:0][AW-1:0] addr_offsets;
    logic trig_valid;
    logic [IW-1:0] trig_instr;
    logic tready;
    logic tvalid, tlast, overrun;
    logic [DW-1:0] tdata;
    logic [VW-1:0] tuser;
    logic [NV-1:0] active;
    logic [7:0] drop;
    logic s_tvalid, s_tlast, s_overrun;
    logic [DW-1:0] s_tdata;
    logic [0:0] s_tuser;
    logic [1:0] s_active;
    logic [7:0] s_drop;

    voice_read_scheduler #(.PERIOD_RST(PRST)) dut (
        .clk(clk), .rst_n(rst_n), .sample_period(sample_period), .setup_complete(setup_complete),
        .addr_offsets(addr_offsets), .trig_valid(trig_valid), .trig_instr(trig_instr),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata), .m_axis_tuser(tuser),
        .m_axis_tlast(tlast), .active_voices(active), .overrun(overrun), .drop_count(drop));

    voice_read_scheduler #(.NUM_VOICES(2), .PERIOD_RST(PRST)) dut_small (
        .clk(clk), .rst_n(rst_n), .sample_period(sample_period), .setup_complete(setup_complete),
        .addr_offsets(addr_offsets), .trig_valid(trig_valid), .trig_instr(trig_instr),
        .m_axis_tvalid(s_tvalid), .m_axis_tready(1'b1), .m_axis_tdata(s_tdata), .m_axis_tuser(s_tuser),
        .m_axis_tlast(s_tlast), .active_voices(s_active), .overrun(s_overrun), .drop_count(s_drop));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;

    // Reference model: voice table plus one output slot, advanced once per clock.
    bit m_act[NV], m_pend[NV];
    longint m_addr[NV], m_stop[NV];
    int m_ins[NV];
    int m_ptr, m_cnt, m_hold, m_ticks, m_drop;
    bit m_tv, m_tlast, m_ovr;
    longint m_taddr;
    int m_tins, m_thold, m_tuser;

    logic [AW-1:0] log_addr[$];
    logic log_last[$];
    int log_user[$], log_hold[$], log_cyc[$];
    logic [AW:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 0; m_pend[v] = 0; m_addr[v] = 0; m_stop[v] = 0; m_ins[v] = 0;
        end
        m_ptr = 0; m_cnt = 0; m_hold = PRST; m_tv = 0; m_ovr = 0; m_drop = 0;
    endtask

    task automatic model_step();
        bit tick, ld, tdrop, ovr_hit;
        int g, ts, tins;
        longint lo, hi;
        tick = (m_cnt == m_hold * CS - 1);
        ld = !m_tv || tready;
        g = -1;
        if (ld && setup_complete)
            for (int k = 0; k < NV; k++)
                if (g < 0 && m_pend[(m_ptr + k) % NV]) g = (m_ptr + k) % NV;
        ts = -1; tdrop = 0; tins = int'(trig_instr); lo = 0; hi = 0;
        if (trig_valid && setup_complete) begin
            if (tins < NI) begin lo = addr_offsets[tins]; hi = addr_offsets[tins+1]; end
            if (lo >= hi) tdrop = 1;
            else begin
                for (int v = 0; v < NV; v++) if (ts < 0 && m_act[v] && m_ins[v] == tins) ts = v;
                for (int v = 0; v < NV; v++) if (ts < 0 && !m_act[v]) ts = v;
                if (ts < 0) tdrop = 1;
            end
        end
        ovr_hit = 0;
        if (tick && setup_complete)
            for (int v = 0; v < NV; v++) if (m_pend[v] && v != g && v != ts) ovr_hit = 1;
        if (ld) begin
            m_tv = (g >= 0);
            if (g >= 0) begin
                m_taddr = m_addr[g]; m_tins = m_ins[g]; m_thold = m_hold; m_tuser = g;
                m_tlast = (m_addr[g] + CWD >= m_stop[g]);
            end
        end
        if (g >= 0) begin
            m_pend[g] = 0; m_addr[g] += CWD;
            if (m_tlast) m_act[g] = 0;
            m_ptr = (g + 1) % NV;
        end
        if (tick && setup_complete) for (int v = 0; v < NV; v++) if (m_act[v]) m_pend[v] = 1;
        if (ts >= 0) begin
            m_act[ts] = 1; m_pend[ts] = 1; m_addr[ts] = lo; m_stop[ts] = hi; m_ins[ts] = tins;
        end
        if (tdrop && m_drop < 255) m_drop++;
        if (ovr_hit) m_ovr = 1;
        if (!setup_complete) for (int v = 0; v < NV; v++) begin m_act[v] = 0; m_pend[v] = 0; end
        if (tick) begin m_cnt = 0; m_hold = int'(sample_period); m_ticks++; end
        else m_cnt++;
    endtask

    task automatic check_outputs();
        logic [DW-1:0] ed;
        logic [NV-1:0] ea;
        chk("tvalid", tvalid, m_tv);
        if (m_tv) begin
            ed = {IW'(m_tins), PW'(m_thold), AW'(m_taddr)};
            chk("tdata", tdata, ed);
            chk("tuser", tuser, m_tuser);
            chk("tlast", tlast, m_tlast);
        end
        for (int v = 0; v < NV; v++) ea[v] = m_act[v];
        chk("active", active, ea);
        chk("overrun", overrun, m_ovr);
        chk("drop", drop, m_drop);
    endtask

    // Called at a falling edge: check, record any handshake, advance model, move to next falling edge.
    task automatic cycle();
        check_outputs();
        if (tvalid && tready) begin
            log_addr.push_back(tdata[AW-1:0]); log_last.push_back(tlast);
            log_user.push_back(int'(tuser)); log_hold.push_back(int'(tdata[AW+PW-1:AW]));
            log_cyc.push_back(cyc);
        end
        if (!rst_n) model_reset(); else model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_log();
        log_addr.delete(); log_last.delete(); log_user.delete(); log_hold.delete(); log_cyc.delete();
    endtask

    task automatic trigger(input int instr);
        trig_valid = 1'b1; trig_instr = IW'(instr);
        cycle();
        trig_valid = 1'b0;
    endtask

    task automatic wait_ticks(input int k);
        int t0, budget;
        t0 = m_ticks; budget = 400;
        while (m_ticks < t0 + k && budget > 0) begin cycle(); budget--; end
        chk("tick_wait_timeout", budget == 0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] held;
        logic [AW:0] got;
        int base;
        sample_period = PW'(PRST); setup_complete = 1'b0; trig_valid = 1'b0; trig_instr = '0; tready = 1'b1;
        addr_offsets[0] = 24'd0; addr_offsets[1] = 24'd16; addr_offsets[2] = 24'd40; addr_offsets[3] = 24'd64;
        m_ticks = 0;
        model_reset();
        @(negedge clk);
        chk("rst_tvalid", tvalid, 1'b0); chk("rst_tdata", tdata, '0); chk("rst_tuser", tuser, '0);
        chk("rst_tlast", tlast, 1'b0); chk("rst_drop", drop, 8'd0);
        run(2);
        rst_n = 1'b1; setup_complete = 1'b1;
        run(3);

        // Single voice of instrument 1 walks its span one beat per chunk.
        clear_log();
        trigger(1);
        run(130);
        exp_q = '{{1'b0, 24'd16}, {1'b0, 24'd24}, {1'b1, 24'd32}};
        chk("t2_count", log_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            got = (i < log_addr.size()) ? {log_last[i], log_addr[i]} : '1;
            chk("t2_beat", got, exp_q.pop_front());
        end
        chk("t2_gap", (log_cyc.size() == 3) ? log_cyc[2] - log_cyc[1] : -1, CS * PRST);
        chk("t2_idle", active, '0);

        // Three voices in consecutive cycles are issued round-robin.
        clear_log();
        trigger(0); trigger(1); trigger(2);
        run(130);
        for (int i = 0; i < 3; i++) chk("t3_tuser", (i < log_user.size()) ? log_user[i] : -1, i);

        // Backpressure: beat held, second tick finds request still pending.
        tready = 1'b0;
        trigger(1);
        run(3);
        held = {2'd1, 14'd5, 24'd16};
        chk("t4_tvalid", tvalid, 1'b1);
        chk("t4_held", tdata, held);
        wait_ticks(1);
        chk("t4_ovr_tick1", overrun, 1'b0);
        wait_ticks(1);
        chk("t4_ovr_tick2", overrun, 1'b1);
        wait_ticks(1);
        chk("t4_held_end", tdata, held);

        // Reset asserted while a beat is stalled.
        rst_n = 1'b0;
        #1;
        chk("t1_tvalid", tvalid, 1'b0); chk("t1_active", active, '0);
        chk("t1_drop", drop, 8'd0); chk("t1_ovr", overrun, 1'b0);
        model_reset();
        run(2);
        rst_n = 1'b1;
        tready = 1'b1;

        // Two-voice instance runs out of voices on the third instrument.
        do_reset();
        trigger(0); trigger(1); trigger(2);
        run(3);
`ifdef VOICE_STEAL_EN
        chk("t5_small_drop", s_drop, 8'd0);
`else
        chk("t5_small_drop", s_drop, 8'd1);
`endif
        chk("t5_small_active", s_active, 2'b11);
        chk("t5_main_drop", drop, 8'd0);

        // Period change mid-chunk reaches the period field only after the next tick.
        do_reset();
        run(2);
        sample_period = 14'd3;
        clear_log();
        trigger(2);
        run(100);
        chk("t6_count", log_hold.size(), 3);
        chk("t6_hold0", (log_hold.size() > 0) ? log_hold[0] : -1, PRST);
        chk("t6_hold1", (log_hold.size() > 1) ? log_hold[1] : -1, 3);
        chk("t6_gap", (log_cyc.size() > 2) ? log_cyc[2] - log_cyc[1] : -1, 3 * CS);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            trig_valid = ($urandom_range(0, 9) == 0);
            trig_instr = IW'($urandom_range(0, 3));
            tready = ($urandom_range(0, 9) < 7);
            setup_complete = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 199) == 0) sample_period = PW'($urandom_range(2, 6));
            if (n == 750) begin
                base = $urandom_range(0, 20);
                for (int i = 0; i <= NI; i++) begin
                    addr_offsets[i] = AW'(base);
                    base = base + $urandom_range(0, 30);
                end
            end
            cycle();
        end
        trig_valid = 1'b0; setup_complete = 1'b1; tready = 1'b1;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
